bram_fifo_ctrl: RTL

Synchronous FIFO controller that sits directly upstream and downstream of an alta_bram in simple-dual-port mode: port A write-only, port B read-only (PORTB_READONLY=1, PORTB_OUTREG=0, single clock domain).
- Generates write and read addresses and enables for the BRAM.
- Absorbs the BRAM's 1-cycle read latency in a 2-entry output skid buffer.
- Presents valid/ready streams on both sides, with full throughput of one word per cycle.

---
 rtl/bram_fifo_ctrl_pkg.sv | 29 ++
 rtl/bram_fifo_skid.sv | 63 ++++++
 rtl/bram_fifo_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/bram_fifo_ctrl_pkg.sv
// bram_fifo_ctrl_pkg
// Shared constants for the BRAM FIFO controller and its integrating wrapper.
//   BRAM_ADDR_W / BRAM_DATA_W : fixed alta_bram port geometry.
//   port_width_e              : codes for the PORTA_WIDTH / PORTB_WIDTH settings.
//   port_width_code()         : maps a FIFO DATA_W to the matching width code, so the
//                               wrapper can derive both BRAM width settings from DATA_W.
package bram_fifo_ctrl_pkg;

  localparam int BRAM_ADDR_W = 12;
  localparam int BRAM_DATA_W = 18;

  typedef enum logic [2:0] {
    PW_1  = 3'd0,
    PW_2  = 3'd1,
    PW_4  = 3'd2,
    PW_9  = 3'd3,
    PW_18 = 3'd4
  } port_width_e;

  // Smallest BRAM port width that holds a data_w-bit word.
  function automatic port_width_e port_width_code(input int data_w);
    if (data_w <= 1)      return PW_1;
    else if (data_w <= 2) return PW_2;
    else if (data_w <= 4) return PW_4;
    else if (data_w <= 9) return PW_9;
    else                  return PW_18;
  endfunction

endpackage

// File: rtl/bram_fifo_skid.sv
// bram_fifo_skid
// Two-entry valid/ready buffer that catches words returning from the BRAM read port.
// A word arriving while the buffer is empty is presented straight through, so the
// read-return cycle already shows valid data; it is stored only if not taken that cycle.
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        synchronous clear (drops stored words and the arriving word)
//   cap_valid_i    a BRAM read returns this cycle; cap_data_i carries it
//   ready_i        downstream ready
//   valid_o/data_o head of the buffer (data_o is zero when nothing is valid)
//   pop_o          handshake completed this cycle
//   cnt_o          number of stored words (0..2)
module bram_fifo_skid #(
  parameter int DATA_W = 18
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              cap_valid_i,
  input  logic [DATA_W-1:0] cap_data_i,
  input  logic              ready_i,
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              pop_o,
  output logic [1:0]        cnt_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              head_q;
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic              has_data;
  logic              push;
  logic              deq;
  logic              tail;

  assign has_data = (cnt_q != 2'd0);
  assign valid_o  = has_data | cap_valid_i;
  assign data_o   = has_data ? mem_q[head_q] : (cap_valid_i ? cap_data_i : '0);
  assign pop_o    = valid_o & ready_i;
  assign deq      = pop_o & has_data;
  // An arriving word consumed in the same cycle through the bypass is never stored.
  assign push     = cap_valid_i & ~(pop_o & ~has_data);
  assign tail     = head_q ^ cnt_q[0];
  assign cnt_d    = cnt_q + {1'b0, push} - {1'b0, deq};
  assign cnt_o    = cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else if (clear_i) begin
      cnt_q  <= 2'd0;
      head_q <= 1'b0;
    end else begin
      if (push) mem_q[tail] <= cap_data_i;
      if (deq)  head_q <= ~head_q;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl
// Synchronous FIFO controller wrapped around an external simple-dual-port alta_bram
// (port A write-only, port B read-only, no output register).
// Ports:
//   Clk, AsyncReset         clock (also BRAM Clk0), asynchronous active-high reset
//   Flush                   synchronous clear of all FIFO contents
//   InData/InValid/InReady  write stream
//   OutData/OutValid/OutReady read stream
//   Level                   words held: BRAM + in-flight read + skid buffer
//   BramDataIn/BramAddrA/BramWeA  BRAM port A (write)
//   BramAddrB/BramReB/BramDataOut BRAM port B (read)
//   BramClkEn               BRAM clock enable, constant 1
module bram_fifo_ctrl
  import bram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_W     = 18,
  parameter int ADDR_W     = 8,
  parameter int ADDR_SHIFT = 0
) (
  input  logic                   Clk,
  input  logic                   AsyncReset,
  input  logic                   Flush,
  input  logic [DATA_W-1:0]      InData,
  input  logic                   InValid,
  output logic                   InReady,
  output logic [DATA_W-1:0]      OutData,
  output logic                   OutValid,
  input  logic                   OutReady,
  output logic [ADDR_W+1:0]      Level,
  output logic [DATA_W-1:0]      BramDataIn,
  output logic [BRAM_ADDR_W-1:0] BramAddrA,
  output logic                   BramWeA,
  output logic [BRAM_ADDR_W-1:0] BramAddrB,
  output logic                   BramReB,
  output logic                   BramClkEn,
  input  logic [DATA_W-1:0]      BramDataOut
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic [ADDR_W:0]   ram_cnt_q;
  logic [ADDR_W:0]   ram_cnt_d;
  logic              rd_pend_q;
  logic [ADDR_W+1:0] level_q;
  logic [ADDR_W+1:0] level_d;
  logic              wr_fire;
  logic              rd_issue;
  logic              pop;
  logic [1:0]        skid_cnt;
  logic [2:0]        occ_after_pop;

  // Held low while reset is asserted so the writer never sees a stale ready.
  assign InReady = ~AsyncReset & ~Flush & (ram_cnt_q < DEPTH);
  assign wr_fire = InValid & InReady;

  // Skid occupancy once this cycle's pop is applied, counting the in-flight read as
  // already occupying a slot; a new read is only issued if it is guaranteed a slot.
  assign occ_after_pop = {1'b0, skid_cnt} + {2'b00, rd_pend_q} - {2'b00, pop};
  // ram_cnt is registered, so a word written this cycle is not read until the next.
  assign rd_issue = ~Flush & (ram_cnt_q != '0) & (occ_after_pop < 3'd2);

  assign ram_cnt_d = ram_cnt_q + {{ADDR_W{1'b0}}, wr_fire} - {{ADDR_W{1'b0}}, rd_issue};
  // Every word enters via a write and leaves via a pop, so the total tracks those two.
  assign level_d   = level_q + {{(ADDR_W+1){1'b0}}, wr_fire} - {{(ADDR_W+1){1'b0}}, pop};

  assign BramWeA    = wr_fire;
  assign BramDataIn = InData;
  assign BramAddrA  = BRAM_ADDR_W'(wr_ptr_q) << ADDR_SHIFT;
  assign BramReB    = rd_issue;
  assign BramAddrB  = BRAM_ADDR_W'(rd_ptr_q) << ADDR_SHIFT;
  assign BramClkEn  = 1'b1;
  assign Level      = level_q;

  bram_fifo_skid #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk_i       (Clk),
    .rst_i       (AsyncReset),
    .clear_i     (Flush),
    .cap_valid_i (rd_pend_q & ~Flush),
    .cap_data_i  (BramDataOut),
    .ready_i     (OutReady),
    .valid_o     (OutValid),
    .data_o      (OutData),
    .pop_o       (pop),
    .cnt_o       (skid_cnt)
  );

  always_ff @(posedge Clk or posedge AsyncReset) begin
    if (AsyncReset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      level_q   <= '0;
    end else if (Flush) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      ram_cnt_q <= '0;
      rd_pend_q <= 1'b0;
      level_q   <= '0;
    end else begin
      if (wr_fire)  wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_issue) rd_ptr_q <= rd_ptr_q + 1'b1;
      ram_cnt_q <= ram_cnt_d;
      rd_pend_q <= rd_issue;
      level_q   <= level_d;
    end
  end

endmodule
